// File: rtl/sram_peripheral_responder_pkg.sv
// Shared MMIO offsets, status bit positions and data types for the SRAM/MMIO responder.
// The optional timer block is built when RESPONDER_TIMER_EN is defined.
package sram_responder_params;

  typedef logic [15:0] MmioOffset;
  typedef logic [7:0]  TxByte;
  typedef logic [31:0] CpuData;

  localparam MmioOffset OFF_LED     = 16'h0000;
  localparam MmioOffset OFF_SWITCH  = 16'h0004;
  localparam MmioOffset OFF_TIMER   = 16'h0008;
  localparam MmioOffset OFF_COMPARE = 16'h000C;
  localparam MmioOffset OFF_TX_DATA = 16'h0010;
  localparam MmioOffset OFF_STATUS  = 16'h0014;

  typedef enum int unsigned {
    STAT_FIFO_EMPTY  = 0,
    STAT_FIFO_FULL   = 1,
    STAT_TX_OVERFLOW = 2,
    STAT_TIMER_MATCH = 3
  } StatusBit;

  // One initiator request as seen on the data SRAM port.
  typedef struct packed {
    logic       en;
    logic [3:0] strobe;
    CpuData     addr;
    CpuData     wdata;
  } mem_req_t;

  function automatic CpuData status_word(input logic empty, input logic full,
                                         input logic overflow, input logic match);
    CpuData w;
    w                   = '0;
    w[STAT_FIFO_EMPTY]  = empty;
    w[STAT_FIFO_FULL]   = full;
    w[STAT_TX_OVERFLOW] = overflow;
    w[STAT_TIMER_MATCH] = match;
    return w;
  endfunction

endpackage

// File: rtl/sram_peripheral_responder_tx_fifo.sv
// Circular UART-TX byte FIFO; pointers carry one extra wrap bit to tell full from empty.
module sram_tx_fifo
  import sram_responder_params::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic  clock,
  input  logic  reset_,
  input  logic  push,
  input  TxByte push_data,
  output logic  full_c,
  output logic  drop_c,
  input  logic  pop,
  output TxByte head_c,
  output logic  empty_c
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [IDX_W:0] ptr_t;

  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  TxByte slots_mem [DEPTH];
  logic  pop_ok_c;
  logic  push_ok_c;

  assign empty_c   = (wr_ptr_q == rd_ptr_q);
  assign full_c    = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign pop_ok_c  = pop & ~empty_c;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok_c = push & (~full_c | pop_ok_c);
  assign drop_c    = push & full_c & ~pop_ok_c;
  assign head_c    = empty_c ? TxByte'(0) : slots_mem[rd_ptr_q[IDX_W-1:0]];

  always_comb begin : ptr_next
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_c) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop_ok_c)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
  end

  always_ff @(posedge clock or negedge reset_) begin : ptr_state
    if (!reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin : slot_write
    if (push_ok_c) slots_mem[wr_ptr_q[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/sram_peripheral_responder.sv
// Data SRAM responder: word RAM plus LED/switch/timer/UART-TX MMIO window, one-cycle read latency.
// Define RESPONDER_TIMER_EN to build the timer/compare block and timer_interrupt.
module sram_peripheral_responder
  import sram_responder_params::*;
#(
  parameter int unsigned RAM_ADDR_WIDTH = 14,
  parameter logic [31:0] MMIO_BASE      = 32'hBFAF_0000,
  parameter int unsigned TX_FIFO_DEPTH  = 8
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic        data_ram_enabled,
  input  logic [3:0]  data_ram_write_enabled,
  input  logic [31:0] data_ram_address,
  input  logic [31:0] data_ram_write_data,
  output logic [31:0] data_ram_read_data,
  output logic [15:0] led,
  input  logic [7:0]  switch,
  output logic        timer_interrupt,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_ADDR_WIDTH;

  mem_req_t                  req_c;
  logic                      is_mmio_c;
  logic                      wr_c;
  logic                      rd_c;
  logic                      mmio_wr_c;
  logic [13:0]               word_off_c;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx_c;
  logic                      unused_addr_c;

  logic sel_led_c, sel_switch_c, sel_timer_c, sel_compare_c, sel_tx_c, sel_status_c;

  CpuData     read_data_q, read_data_d;
  logic [15:0] led_q, led_d;
  logic [7:0] sw_meta_q, sw_meta_d;
  logic [7:0] sw_sync_q, sw_sync_d;
  logic       overflow_q, overflow_d;
  CpuData     mmio_rdata_c;
  CpuData     timer_rd_c;
  CpuData     compare_rd_c;
  logic       match_c;

  logic  fifo_full_c, fifo_empty_c, fifo_drop_c;
  TxByte fifo_head_c;

  CpuData ram_mem [RAM_DEPTH];

  assign req_c = '{en:     data_ram_enabled,
                   strobe: data_ram_write_enabled,
                   addr:   data_ram_address,
                   wdata:  data_ram_write_data};

  // Address decode: upper half selects the window, word index wraps inside the RAM.
  assign is_mmio_c     = (req_c.addr[31:16] == MMIO_BASE[31:16]);
  assign wr_c          = req_c.en & (|req_c.strobe);
  assign rd_c          = req_c.en & ~(|req_c.strobe);
  assign mmio_wr_c     = wr_c & is_mmio_c;
  assign word_off_c    = req_c.addr[15:2];
  assign ram_idx_c     = req_c.addr[RAM_ADDR_WIDTH+1:2];
  assign unused_addr_c = ^req_c.addr[1:0];

  assign sel_led_c     = (word_off_c == OFF_LED[15:2]);
  assign sel_switch_c  = (word_off_c == OFF_SWITCH[15:2]);
  assign sel_timer_c   = (word_off_c == OFF_TIMER[15:2]);
  assign sel_compare_c = (word_off_c == OFF_COMPARE[15:2]);
  assign sel_tx_c      = (word_off_c == OFF_TX_DATA[15:2]);
  assign sel_status_c  = (word_off_c == OFF_STATUS[15:2]);

  always_ff @(posedge clock) begin : ram_write
    if (wr_c && !is_mmio_c) begin
      for (int i = 0; i < 4; i++) begin
        if (req_c.strobe[i]) ram_mem[ram_idx_c][8*i +: 8] <= req_c.wdata[8*i +: 8];
      end
    end
  end

`ifdef RESPONDER_TIMER_EN
  CpuData timer_q, timer_d;
  CpuData compare_q, compare_d;
  logic   match_q, match_d;

  // Software load beats the increment; a match event beats a same-cycle W1C clear.
  always_comb begin : timer_next
    timer_d   = timer_q + 32'd1;
    compare_d = compare_q;
    match_d   = match_q;
    if (mmio_wr_c && sel_timer_c)   timer_d   = req_c.wdata;
    if (mmio_wr_c && sel_compare_c) compare_d = req_c.wdata;
    if (mmio_wr_c && sel_status_c && req_c.wdata[STAT_TIMER_MATCH]) match_d = 1'b0;
    if (timer_q == compare_q) match_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_) begin : timer_state
    if (!reset_) begin
      timer_q   <= '0;
      compare_q <= 32'hFFFF_FFFF;
      match_q   <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      compare_q <= compare_d;
      match_q   <= match_d;
    end
  end

  assign timer_rd_c   = timer_q;
  assign compare_rd_c = compare_q;
  assign match_c      = match_q;
`else
  logic unused_timer_sel_c;

  assign unused_timer_sel_c = sel_timer_c ^ sel_compare_c;
  assign timer_rd_c         = '0;
  assign compare_rd_c       = '0;
  assign match_c            = 1'b0;
`endif

  sram_tx_fifo #(
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clock     (clock),
    .reset_    (reset_),
    .push      (mmio_wr_c & sel_tx_c),
    .push_data (req_c.wdata[7:0]),
    .full_c    (fifo_full_c),
    .drop_c    (fifo_drop_c),
    .pop       (uart_tx_ready),
    .head_c    (fifo_head_c),
    .empty_c   (fifo_empty_c)
  );

  // TX_DATA and unmapped offsets fall through to zero.
  always_comb begin : mmio_read_mux
    mmio_rdata_c = '0;
    if (sel_led_c)     mmio_rdata_c = {16'h0000, led_q};
    if (sel_switch_c)  mmio_rdata_c = {24'h00_0000, sw_sync_q};
    if (sel_timer_c)   mmio_rdata_c = timer_rd_c;
    if (sel_compare_c) mmio_rdata_c = compare_rd_c;
    if (sel_status_c)  mmio_rdata_c = status_word(fifo_empty_c, fifo_full_c, overflow_q, match_c);
  end

  always_comb begin : reg_next
    read_data_d = read_data_q;
    led_d       = led_q;
    sw_meta_d   = switch;
    sw_sync_d   = sw_meta_q;
    overflow_d  = overflow_q;
    if (mmio_wr_c && sel_led_c) led_d = req_c.wdata[15:0];
    if (mmio_wr_c && sel_status_c && req_c.wdata[STAT_TX_OVERFLOW]) overflow_d = 1'b0;
    if (fifo_drop_c) overflow_d = 1'b1;
    if (rd_c) read_data_d = is_mmio_c ? mmio_rdata_c : ram_mem[ram_idx_c];
  end

  always_ff @(posedge clock or negedge reset_) begin : reg_state
    if (!reset_) begin
      read_data_q <= '0;
      led_q       <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      led_q       <= led_d;
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      overflow_q  <= overflow_d;
    end
  end

  assign data_ram_read_data = read_data_q;
  assign led                = led_q;
  assign timer_interrupt    = match_c;
  assign uart_tx_data       = fifo_head_c;
  assign uart_tx_valid      = ~fifo_empty_c;

endmodule

// File: tb/tb_sram_peripheral_responder.sv
// Randomized self-checking bench for sram_peripheral_responder against a transaction-level model.
`timescale 1ns/1ps
module tb_sram_peripheral_responder;

  localparam int unsigned RAM_AW = 14;
  localparam logic [31:0] BASE   = 32'hBFAF_0000;
  localparam int unsigned DEPTH  = 8;
`ifdef RESPONDER_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_ = 1'b0;
  logic        data_ram_enabled = 1'b0;
  logic [3:0]  data_ram_write_enabled = 4'h0;
  logic [31:0] data_ram_address = 32'h0;
  logic [31:0] data_ram_write_data = 32'h0;
  logic [31:0] data_ram_read_data;
  logic [15:0] led;
  logic [7:0]  sw = 8'h00;
  logic        timer_interrupt;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;

  sram_peripheral_responder #(
    .RAM_ADDR_WIDTH (RAM_AW),
    .MMIO_BASE      (BASE),
    .TX_FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock                  (clock),
    .reset_                 (reset_),
    .data_ram_enabled       (data_ram_enabled),
    .data_ram_write_enabled (data_ram_write_enabled),
    .data_ram_address       (data_ram_address),
    .data_ram_write_data    (data_ram_write_data),
    .data_ram_read_data     (data_ram_read_data),
    .led                    (led),
    .switch                 (sw),
    .timer_interrupt        (timer_interrupt),
    .uart_tx_data           (uart_tx_data),
    .uart_tx_valid          (uart_tx_valid),
    .uart_tx_ready          (uart_tx_ready)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [31:0] m_ram [int];
  logic [7:0]  m_fifo [$];
  logic [15:0] m_led = 16'h0;
  bit          m_ovf = 1'b0;
  bit          m_match = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic [31:0] m_cmp = 32'hFFFF_FFFF;
  logic [31:0] m_tbase = 32'h0;
  int unsigned m_tedge = 0;
  int unsigned cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mmio(input logic [15:0] off);
    return {BASE[31:16], off};
  endfunction

  function automatic bit in_window(input logic [31:0] a);
    return a[31:16] == BASE[31:16];
  endfunction

  // Timer value visible during the cycle following edge number 'at'.
  function automatic logic [31:0] m_timer(input int unsigned at);
    return m_tbase + 32'(at - m_tedge);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int idx;
    if (!in_window(a)) begin
      idx = int'(a[RAM_AW+1:2]);
      return m_ram.exists(idx) ? m_ram[idx] : 32'h0;
    end
    case ({a[15:2], 2'b00})
      16'h0000: return {16'h0, m_led};
      16'h0004: return {24'h0, sw};
      16'h0008: return TIMER_ON ? m_timer(cyc) : 32'h0;
      16'h000C: return TIMER_ON ? m_cmp : 32'h0;
      16'h0014: return {28'h0, m_match, m_ovf, m_fifo.size() == DEPTH, m_fifo.size() == 0};
      default:  return 32'h0;
    endcase
  endfunction

  // One clock: predict from the inputs now on the bus, advance, then compare every output.
  task automatic tick();
    logic [31:0] a, d, rd_exp, t_now, cmp_old, w;
    logic [3:0]  s;
    bit          wr, rd, mm, pop_now;
    int          idx;
    a       = data_ram_address;
    d       = data_ram_write_data;
    s       = data_ram_write_enabled;
    wr      = data_ram_enabled && (s != 4'h0);
    rd      = data_ram_enabled && (s == 4'h0);
    mm      = in_window(a);
    rd_exp  = model_read(a);
    pop_now = uart_tx_ready && (m_fifo.size() > 0);
    t_now   = m_timer(cyc);
    cmp_old = m_cmp;
    @(posedge clock);
    #1;
    cyc++;
    if (rd) m_rdata = rd_exp;
    if (pop_now) void'(m_fifo.pop_front());
    if (wr && !mm) begin
      idx = int'(a[RAM_AW+1:2]);
      w = m_ram.exists(idx) ? m_ram[idx] : 32'h0;
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      m_ram[idx] = w;
    end
    if (wr && mm) begin
      case ({a[15:2], 2'b00})
        16'h0000: m_led = d[15:0];
        16'h0008: begin m_tbase = d; m_tedge = cyc; end
        16'h000C: m_cmp = d;
        16'h0010: if (m_fifo.size() < DEPTH) m_fifo.push_back(d[7:0]); else m_ovf = 1'b1;
        16'h0014: begin
          if (d[2]) m_ovf = 1'b0;
          if (d[3]) m_match = 1'b0;
        end
        default: ;
      endcase
    end
    if (TIMER_ON && (t_now == cmp_old)) m_match = 1'b1;
    check("rdata", data_ram_read_data, m_rdata);
    check("led", 32'(led), 32'(m_led));
    check("tx_valid", 32'(uart_tx_valid), 32'(m_fifo.size() > 0));
    check("tx_data", 32'(uart_tx_data), 32'((m_fifo.size() > 0) ? m_fifo[0] : 8'h00));
    check("irq", 32'(timer_interrupt), 32'(m_match));
  endtask

  task automatic bus(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    data_ram_enabled       = 1'b1;
    data_ram_write_enabled = s;
    data_ram_address       = a;
    data_ram_write_data    = d;
    tick();
    data_ram_enabled       = 1'b0;
    data_ram_write_enabled = 4'h0;
  endtask

  task automatic idle();
    data_ram_enabled = 1'b0;
    tick();
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus(4'h0, a, 32'h0);
    check(tag, data_ram_read_data, exp);
  endtask

  task automatic apply_reset();
    reset_           = 1'b0;
    data_ram_enabled = 1'b0;
    data_ram_write_enabled = 4'h0;
    repeat (2) begin
      @(posedge clock);
      cyc++;
    end
    #1;
    reset_ = 1'b1;
    m_led = 16'h0;
    m_fifo.delete();
    m_ovf = 1'b0;
    m_match = 1'b0;
    m_rdata = 32'h0;
    m_cmp = 32'hFFFF_FFFF;
    m_tbase = 32'h0;
    m_tedge = cyc;
    check("rst_rdata", data_ram_read_data, 32'h0);
    check("rst_led", 32'(led), 32'h0);
    check("rst_valid", 32'(uart_tx_valid), 32'h0);
    check("rst_txdata", 32'(uart_tx_data), 32'h0);
    check("rst_irq", 32'(timer_interrupt), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k, idx, roff;
    logic [15:0] hi;
    logic [31:0] a;
    logic [3:0]  s;

    apply_reset();

    // Byte-strobe merge on a RAM word
    bus(4'hF, 32'h0000_0100, 32'hDEAD_BEEF);
    bus(4'b0010, 32'h0000_0100, 32'h0000_5500);
    rd_chk("ram_merge", 32'h0000_0100, 32'hDEAD_55EF);
    bus(4'hF, 32'h0000_0104, 32'h1111_1111);
    check("rd_hold_after_wr", data_ram_read_data, 32'hDEAD_55EF);

    // Aliasing through ignored upper address bits
    bus(4'hF, 32'h0001_0200, 32'hCAFE_F00D);
    rd_chk("ram_alias", 32'h7FFC_0200, 32'hCAFE_F00D);

    // Random RAM / LED / unmapped traffic, back to back
    for (int n = 0; n < 400; n++) begin
      k   = $urandom_range(0, 9);
      idx = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7)
                                        : int'((1 << RAM_AW) - 1) - $urandom_range(0, 7);
      hi  = 16'($urandom);
      if (hi == BASE[31:16]) hi = ~hi;
      a   = {hi, 16'(idx << 2)};
      if (k <= 3 || (k <= 6 && !m_ram.exists(idx))) begin
        s = m_ram.exists(idx) ? 4'($urandom_range(1, 15)) : 4'hF;
        bus(s, a, $urandom);
      end else if (k <= 6) begin
        bus(4'h0, a, 32'h0);
      end else if (k == 7) begin
        bus(4'($urandom_range(1, 15)), mmio(16'h0000), $urandom);
      end else if (k == 8) begin
        bus(4'h0, mmio(16'h0000), 32'h0);
      end else begin
        roff = 'h18 + 4 * $urandom_range(0, 100);
        bus(($urandom_range(0, 1) != 0) ? 4'hF : 4'h0, mmio(16'(roff)), $urandom);
      end
    end

    // LED, switch sync, write-only and unmapped offsets
    bus(4'hF, mmio(16'h0000), 32'h1234_ABCD);
    check("led_port", 32'(led), 32'h0000_ABCD);
    rd_chk("led_read", mmio(16'h0000), 32'h0000_ABCD);
    sw = 8'h5A;
    idle();
    idle();
    rd_chk("switch_read", mmio(16'h0004), 32'h0000_005A);
    rd_chk("txdata_read", mmio(16'h0010), 32'h0);
    bus(4'hF, mmio(16'h0040), 32'hFFFF_FFFF);
    rd_chk("unmapped_read", mmio(16'h0040), 32'h0);

    // FIFO overflow then drain in order
    uart_tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) bus(4'hF, mmio(16'h0010), 32'(i));
    rd_chk("stat_full_ovf", mmio(16'h0014), 32'h6);
    uart_tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_byte", 32'(uart_tx_data), 32'(i));
      idle();
    end
    check("drain_empty", 32'(uart_tx_valid), 32'h0);
    rd_chk("stat_empty_ovf", mmio(16'h0014), 32'h5);
    bus(4'hF, mmio(16'h0014), 32'h4);
    rd_chk("stat_ovf_clr", mmio(16'h0014), 32'h1);

    // Full FIFO with push and pop in the same cycle
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus(4'hF, mmio(16'h0010), 32'h20 + 32'(i));
    uart_tx_ready = 1'b1;
    bus(4'hF, mmio(16'h0010), 32'hA5);
    uart_tx_ready = 1'b0;
    rd_chk("stat_full_pushpop", mmio(16'h0014), 32'h2);
    uart_tx_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check("pp_byte", 32'(uart_tx_data), 32'h20 + 32'(i));
      idle();
    end
    check("pp_last", 32'(uart_tx_data), 32'hA5);
    idle();
    check("pp_empty", 32'(uart_tx_valid), 32'h0);

    // Random push / ready mix
    for (int n = 0; n < 200; n++) begin
      uart_tx_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) != 0) bus(4'hF, mmio(16'h0010), $urandom);
      else if ($urandom_range(0, 3) == 0) bus(4'h0, mmio(16'h0014), 32'h0);
      else idle();
    end
    bus(4'hF, mmio(16'h0014), 32'h4);
    uart_tx_ready = 1'b1;
    repeat (DEPTH + 1) idle();

    // Timer compare, W1C clear and wrap
    bus(4'hF, mmio(16'h0008), 32'h0);
    bus(4'hF, mmio(16'h000C), 32'd10);
    repeat (20) idle();
    check("tmr_irq_set", 32'(timer_interrupt), 32'(TIMER_ON));
    rd_chk("tmr_status", mmio(16'h0014), TIMER_ON ? 32'h9 : 32'h1);
    bus(4'hF, mmio(16'h0014), 32'h8);
    check("tmr_irq_clr", 32'(timer_interrupt), 32'h0);
    bus(4'hF, mmio(16'h000C), 32'h8000_0000);
    rd_chk("cmp_read", mmio(16'h000C), TIMER_ON ? 32'h8000_0000 : 32'h0);
    bus(4'hF, mmio(16'h0008), 32'hFFFF_FFFF);
    idle();
    idle();
    rd_chk("tmr_wrap", mmio(16'h0008), TIMER_ON ? 32'h1 : 32'h0);

    // Reset in the middle of a read and a partial FIFO fill
    uart_tx_ready = 1'b0;
    bus(4'hF, mmio(16'h0000), 32'h5555);
    bus(4'hF, mmio(16'h0010), 32'h77);
    bus(4'hF, mmio(16'h0010), 32'h78);
    data_ram_enabled       = 1'b1;
    data_ram_write_enabled = 4'h0;
    data_ram_address       = 32'h0000_0100;
    #3;
    apply_reset();
    rd_chk("stat_after_rst", mmio(16'h0014), 32'h1);
    rd_chk("ram_keep", 32'h0000_0100, 32'hDEAD_55EF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_peripheral_responder.md
Name: sram_peripheral_responder

Overview:
Responder end of the core's data SRAM interface (enable, 4-bit byte write strobe, address, write data, read data). Decodes each access to a word-addressed backing RAM or to a small memory-mapped peripheral window. The window holds LED, switch, free-running timer/compare and a UART-TX FIFO. Sits at SoC top beside cpu_core; returns read data with a fixed one-cycle latency, matching the initiator's expectation.

Parameters:
RAM_ADDR_WIDTH, 14, word-index width of backing RAM (depth 2^RAM_ADDR_WIDTH words)
MMIO_BASE, 32'hBFAF_0000, peripheral window base; window size 64 KiB
TX_FIFO_DEPTH, 8, UART-TX FIFO entries, power of two >= 2

Ports:
clock  input  1  single clock
reset_  input  1  asynchronous active-low reset
data_ram_enabled  input  1  access request this cycle
data_ram_write_enabled  input  4  byte write strobes; all-zero means read
data_ram_address  input  32  byte address; bits [1:0] ignored
data_ram_write_data  input  32  write data
data_ram_read_data  output  32  read data, valid the cycle after a read request
led  output  16  LED register
switch  input  8  asynchronous board switches
timer_interrupt  output  1  sticky timer-match flag
uart_tx_data  output  8  FIFO head byte
uart_tx_valid  output  1  FIFO non-empty
uart_tx_ready  input  1  consumer accepts head when valid & ready

Behaviour:
- Reset (async assert, sync release): read_data=0, led=0, timer=0, compare=32'hFFFF_FFFF, status flags=0, FIFO empty (valid=0, data=0), switch synchronizers=0. RAM contents not reset. Reset mid-access cancels the pending read; read_data is 0 after release.
- Decode: address[31:16]==MMIO_BASE[31:16] -> MMIO, else RAM at index address[RAM_ADDR_WIDTH+1:2]; higher bits ignored (aliasing/wrap).
- RAM write: on the clock edge, each strobe bit i writes byte i. RAM read: registered; data_ram_read_data holds the addressed word one cycle after request and is held until the next read. Writes leave read_data unchanged. Back-to-back reads are pipelined, one per cycle.
- MMIO offsets (address[15:0]): 0x00 LED RW (bits[15:0]); 0x04 SWITCH RO (2-flop synchronized, zero-extended); 0x08 TIMER RW; 0x0C COMPARE RW; 0x10 TX_DATA WO (byte[7:0] pushed); 0x14 STATUS: bit0 fifo_empty, bit1 fifo_full, bit2 tx_overflow (sticky), bit3 timer_match (sticky). Writing 1 to bit2/bit3 clears that bit; bits 0/1 are RO.
- MMIO writes occur when any strobe is set; full word written (strobe pattern otherwise ignored). Unmapped offsets read 0; writes to them are ignored. Reads of TX_DATA return 0.
- Timer: increments by 1 every cycle, wraps 2^32-1 -> 0. A software write in the same cycle wins (loads the written value, no increment). When timer==compare, timer_match is set. A set event in the same cycle as a W1C clear: set wins. timer_interrupt = timer_match.
- TX FIFO: circular, pointers one bit wider than the index. Push on TX_DATA write; pop on valid & ready. Full with simultaneous pop: push accepted. Full with no pop: byte dropped, tx_overflow set. Empty: pop ignored. uart_tx_data shows the head combinationally from registered storage.

Optional Feature:
RESPONDER_TIMER_EN: defined -> timer, compare, timer_match and timer_interrupt as above. Undefined -> no timer logic; TIMER/COMPARE read 0, writes ignored; STATUS bit3 reads 0; timer_interrupt tied 0.

Decomposition:
- Package sram_responder_params: MMIO offset localparams, StatusBit enum (bit positions), typedef MmioOffset (16-bit), typedef TxByte (8-bit), CpuData (32-bit).
- Sub-module sram_tx_fifo (parameter DEPTH; push/data/full, pop/head/empty); RAM, decode and registers stay in the top.

Test Plan:
- Write 0xDEADBEEF to 0x0000_0100 (strobe 4'hF), then write strobe 4'b0010 data 0x0000_5500, then read -> read_data 0xDEAD55EF exactly one cycle after the read request.
- Write LED 0x1234_ABCD, read LED -> 0x0000_ABCD; led=16'hABCD. Set switch=8'h5A -> SWITCH reads 0x5A after 2-flop sync.
- Write TIMER 0, COMPARE 10 -> timer_interrupt rises when the timer reaches 10. Write STATUS 0x8 -> timer_interrupt clears. Write TIMER 0xFFFF_FFFF -> timer reads 0x0000_0001 two cycles later (wrap).
- uart_tx_ready=0, push 9 bytes -> STATUS 0x6 (full+overflow). Ready=1 -> bytes 1..8 are output in order, then valid=0 and STATUS bit0=1.
- FIFO full, push and pop in the same cycle -> no overflow, still full, new byte is output last.
- Assert reset_ low mid-read and mid-FIFO fill -> read_data=0, FIFO empty, led=0; RAM word from the first test still reads 0xDEAD55EF.
